// File: rtl/exp_filter_sequencer.sv
// Frame sequencer for the per-bin exponential filter: load a frame, then drain it.
// Optional EXP_SEQ_PEAK_EN adds a registered per-frame peak output.
module exp_filter_sequencer #(
    parameter int NUM_BINS = 40,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] filt_addr,
    output logic [DATA_W-1:0] filt_in,
    output logic              filt_write,
    input  logic [DATA_W-1:0] filt_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    input  logic              out_ready,
`ifdef EXP_SEQ_PEAK_EN
    output logic [DATA_W-1:0] peak,
`endif
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        LOAD,
        FLUSH,
        DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_done;
`ifdef EXP_SEQ_PEAK_EN
    logic [DATA_W-1:0] run_max;
`endif

    logic accept;
    logic out_fire;
    logic advance;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // filt_addr tracks rd_idx in DRAIN, so filt_out is always the bin being captured
    assign advance  = (state == DRAIN) & ~rd_done & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            wr_idx     <= '0;
            rd_idx     <= '0;
            rd_done    <= 1'b0;
            in_ready   <= 1'b0;
            filt_addr  <= '0;
            filt_in    <= '0;
            filt_write <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
`ifdef EXP_SEQ_PEAK_EN
            run_max    <= '0;
            peak       <= '0;
`endif
        end else begin
            filt_write <= 1'b0;
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        filt_write <= 1'b1;
                        filt_addr  <= wr_idx;
                        filt_in    <= in_data;
                        busy       <= 1'b1;
                        if (wr_idx == LAST) begin
                            wr_idx   <= '0;
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    rd_idx    <= '0;
                    rd_done   <= 1'b0;
                    filt_addr <= '0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_data  <= filt_out;
                        out_addr  <= rd_idx;
                        out_last  <= (rd_idx == LAST);
`ifdef EXP_SEQ_PEAK_EN
                        if (rd_idx == '0 || filt_out > run_max) begin
                            run_max <= filt_out;
                        end
`endif
                        if (rd_idx == LAST) begin
                            rd_done <= 1'b1;
                        end else begin
                            rd_idx    <= rd_idx + 1'b1;
                            filt_addr <= rd_idx + 1'b1;
                        end
                    end
                    if (out_fire && out_last) begin
                        out_last <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        rd_idx   <= '0;
                        rd_done  <= 1'b0;
                        state    <= LOAD;
`ifdef EXP_SEQ_PEAK_EN
                        peak     <= run_max;
`endif
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
